// File: rtl/imm_encoder_pkg.sv
// Shared immediate-format definitions: format encodings, legal range bounds and the
// instruction bit positions each format's immediate occupies.
`timescale 1ns/1ps
package imm_encoder_pkg;

  typedef enum logic [2:0] {
    IMM_I = 3'b000,
    IMM_S = 3'b001,
    IMM_B = 3'b010,
    IMM_U = 3'b011,
    IMM_J = 3'b100
  } imm_sel_e;

  localparam int signed IMM12_MIN  = -2048;
  localparam int signed IMM12_MAX  = 2047;
  localparam int signed IMM_B_MIN  = -4096;
  localparam int signed IMM_B_MAX  = 4094;
  localparam int signed IMM_J_MIN  = -1048576;
  localparam int signed IMM_J_MAX  = 1048574;

  localparam logic [31:0] MASK_I = 32'hFFF0_0000;
  localparam logic [31:0] MASK_S = 32'hFE00_0F80;
  localparam logic [31:0] MASK_B = 32'hFE00_0F80;
  localparam logic [31:0] MASK_U = 32'hFFFF_F000;
  localparam logic [31:0] MASK_J = 32'hFFFF_F000;

  function automatic logic [31:0] imm_field_mask(input logic [2:0] sel);
    logic [31:0] m;
    m = '0;
    case (sel)
      IMM_I:   m = MASK_I;
      IMM_S:   m = MASK_S;
      IMM_B:   m = MASK_B;
      IMM_U:   m = MASK_U;
      IMM_J:   m = MASK_J;
      default: m = '0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/imm_encoder_pack.sv
// Combinational immediate packer and range checker: scatters a signed immediate into
// the format's instruction fields and flags values the format cannot represent.
`timescale 1ns/1ps
module imm_pack
  import imm_encoder_pkg::*;
(
  input  logic [2:0]         imm_sel_i,
  input  logic signed [31:0] imm_i,
  input  logic [31:0]        base_i,
  output logic [31:0]        instr_o,
  output logic               err_o
);

  logic [31:0] fields;
  logic        in_range;

  always_comb begin
    fields   = '0;
    in_range = 1'b0;
    case (imm_sel_i)
      IMM_I: begin
        fields   = {imm_i[11:0], 20'b0};
        in_range = (imm_i >= IMM12_MIN) && (imm_i <= IMM12_MAX);
      end
      IMM_S: begin
        fields   = {imm_i[11:5], 13'b0, imm_i[4:0], 7'b0};
        in_range = (imm_i >= IMM12_MIN) && (imm_i <= IMM12_MAX);
      end
      IMM_B: begin
        fields   = {imm_i[12], imm_i[10:5], 13'b0, imm_i[4:1], imm_i[11], 7'b0};
        in_range = (imm_i >= IMM_B_MIN) && (imm_i <= IMM_B_MAX) && !imm_i[0];
      end
      IMM_U: begin
        fields   = {imm_i[31:12], 12'b0};
        in_range = (imm_i[11:0] == 12'h000);
      end
      IMM_J: begin
        fields   = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], 12'b0};
        in_range = (imm_i >= IMM_J_MIN) && (imm_i <= IMM_J_MAX) && !imm_i[0];
      end
      default: begin
        fields   = '0;
        in_range = 1'b0;
      end
    endcase
  end

  // An unrepresentable immediate leaves the skeleton untouched rather than truncating.
  always_comb begin
    err_o   = !in_range;
    instr_o = err_o ? base_i : ((base_i & ~imm_field_mask(imm_sel_i)) | fields);
  end

endmodule

// File: rtl/imm_encoder.sv
// Immediate encoder: packs an immediate into an instruction skeleton behind a single
// ready/valid output register and counts erroneous words delivered downstream.
`timescale 1ns/1ps
module imm_encoder
  import imm_encoder_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2:0]         imm_sel,
  input  logic signed [31:0] imm,
  input  logic [31:0]        base,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [31:0]        instr,
  output logic               err,
  output logic [CNT_W-1:0]   err_count
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  logic [31:0]      pack_instr;
  logic             pack_err;

  logic             out_valid_q, out_valid_d;
  logic [31:0]      instr_q, instr_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] err_count_q, err_count_d;
  logic             load, out_xfer;

  imm_pack u_pack (
    .imm_sel_i (imm_sel),
    .imm_i     (imm),
    .base_i    (base),
    .instr_o   (pack_instr),
    .err_o     (pack_err)
  );

  // Output register may refill in the same cycle it drains, so no bubble under full rate.
  always_comb begin
    in_ready    = !out_valid_q || out_ready;
    load        = in_valid && in_ready;
    out_xfer    = out_valid_q && out_ready;
    out_valid_d = out_valid_q;
    instr_d     = instr_q;
    err_d       = err_q;
    err_count_d = err_count_q;
    if (load) begin
      out_valid_d = 1'b1;
      instr_d     = pack_instr;
      err_d       = pack_err;
    end else if (out_xfer) begin
      out_valid_d = 1'b0;
    end
    if (out_xfer && err_q) begin
      err_count_d = sat_inc(err_count_q);
    end
  end

  // ---- output register stage ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      instr_q     <= '0;
      err_q       <= 1'b0;
      err_count_q <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      instr_q     <= instr_d;
      err_q       <= err_d;
      err_count_q <= err_count_d;
    end
  end

  assign out_valid = out_valid_q;
  assign instr     = instr_q;
  assign err       = err_q;
  assign err_count = err_count_q;

endmodule

// File: tb/tb_imm_encoder.sv
// Scoreboard bench for imm_encoder: directed vectors, boundaries, errors, backpressure,
// random round-trip and mid-stream reset.
`timescale 1ns/1ps
module tb_imm_encoder;

  localparam int CNT_W   = 2;
  localparam int CNT_MAX = 3;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        imm_sel;
  logic signed [31:0] imm;
  logic [31:0]       base;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       instr;
  logic              err;
  logic [CNT_W-1:0]  err_count;

  always #5 clk = ~clk;

  imm_encoder #(.CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .imm_sel   (imm_sel),
    .imm       (imm),
    .base      (base),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .instr     (instr),
    .err       (err),
    .err_count (err_count)
  );

  typedef struct {
    logic [2:0]  sel;
    logic [31:0] imm;
    logic [31:0] base;
    logic [31:0] exp_instr;
    logic        exp_err;
    bit          known;
  } exp_t;

  exp_t sbq[$];
  exp_t e;
  int   n_chk   = 0;
  int   n_fail  = 0;
  int   exp_cnt = 0;
  bit   hold    = 1'b0;
  bit   rnd_rdy = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] immgen(input logic [31:0] i, input logic [2:0] s);
    case (s)
      3'd0:    return {{20{i[31]}}, i[31:20]};
      3'd1:    return {{20{i[31]}}, i[31:25], i[11:7]};
      3'd2:    return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      3'd3:    return {i[31:12], 12'b0};
      3'd4:    return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] fmask(input logic [2:0] s);
    case (s)
      3'd0:       return 32'hFFF0_0000;
      3'd1, 3'd2: return 32'hFE00_0F80;
      3'd3, 3'd4: return 32'hFFFF_F000;
      default:    return 32'h0;
    endcase
  endfunction

  // out_ready updates at posedge+2 so it never races the stimulus at posedge+1
  initial out_ready = 1'b1;
  always @(posedge clk) begin
    #2;
    out_ready = hold ? 1'b0 : (rnd_rdy ? ($urandom_range(0, 3) != 0) : 1'b1);
  end

  logic        pv = 1'b0, pr = 1'b0, pe = 1'b0;
  logic [31:0] pi = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      pv = 1'b0;
    end else begin
      chk("err_count", {30'b0, err_count}, exp_cnt);
      if (pv && !pr) begin
        chk("hold_valid", {31'b0, out_valid}, 32'd1);
        chk("hold_instr", instr, pi);
        chk("hold_err", {31'b0, err}, {31'b0, pe});
      end
      if (out_valid && !out_ready) chk("stall_in_ready", {31'b0, in_ready}, 32'd0);
      if (out_valid && out_ready) begin
        if (sbq.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_word: got instr 0x%08h, expected no word", instr);
        end else begin
          e = sbq.pop_front();
          chk("word_err", {31'b0, err}, {31'b0, e.exp_err});
          if (e.known) begin
            chk("word_instr", instr, e.exp_instr);
          end else if (!e.exp_err) begin
            chk("roundtrip_imm", immgen(instr, e.sel), e.imm);
            chk("base_kept", instr & ~fmask(e.sel), e.base & ~fmask(e.sel));
          end
          if (e.exp_err && exp_cnt < CNT_MAX) exp_cnt++;
        end
      end
      pv = out_valid;
      pr = out_ready;
      pi = instr;
      pe = err;
    end
  end

  task automatic send(input logic [2:0] s, input logic [31:0] im, input logic [31:0] b,
                      input logic [31:0] ei, input logic ee, input bit known);
    exp_t x;
    x.sel = s; x.imm = im; x.base = b; x.exp_instr = ei; x.exp_err = ee; x.known = known;
    imm_sel  = s;
    imm      = im;
    base     = b;
    in_valid = 1'b1;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (in_ready) begin
        sbq.push_back(x);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
    end
    n_chk++;
    n_fail++;
    $display("FAIL send_timeout: in_ready got 0 for 30 cycles, required 1");
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 50; k++) begin
      if (sbq.size() == 0 && !out_valid) return;
      @(posedge clk);
      #1;
    end
    n_chk++;
    n_fail++;
    $display("FAIL drain_timeout: got %0d words pending, required 0", sbq.size());
  endtask

  task automatic send_random();
    logic [2:0] s;
    int         v;
    s = 3'($urandom_range(0, 4));
    case (s)
      3'd0, 3'd1: v = int'($urandom_range(0, 4095)) - 2048;
      3'd2:       v = (int'($urandom_range(0, 4095)) - 2048) * 2;
      3'd3:       v = int'($urandom & 32'hFFFF_F000);
      default:    v = (int'($urandom_range(0, 1048575)) - 524288) * 2;
    endcase
    send(s, v, $urandom, 32'h0, 1'b0, 1'b0);
  endtask

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    imm_sel  = '0;
    imm      = '0;
    base     = '0;
    #12;
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    chk("rst_instr", instr, 32'h0);
    chk("rst_err", {31'b0, err}, 32'd0);
    chk("rst_err_count", {30'b0, err_count}, 32'd0);

    // first edge after release must already accept a request
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    send(3'd0, 32'h0000_07FF, 32'h0000_0013, 32'h7FF0_0013, 1'b0, 1'b1);
    chk("I_latency_valid", {31'b0, out_valid}, 32'd1);
    chk("I_latency_instr", instr, 32'h7FF0_0013);
    send(3'd1, -24,           32'h0000_2023, 32'hFE00_2423, 1'b0, 1'b1);
    send(3'd2, -32,           32'h0000_0063, 32'hFE00_00E3, 1'b0, 1'b1);
    send(3'd4, 4,             32'h0000_00EF, 32'h0040_00EF, 1'b0, 1'b1);
    send(3'd3, 32'h1234_5000, 32'h0000_0037, 32'h1234_5037, 1'b0, 1'b1);
    send(3'd0, -2048,         32'h0000_0013, 32'h8000_0013, 1'b0, 1'b1);
    send(3'd2, 4094,          32'h0000_0063, 32'h7E00_0FE3, 1'b0, 1'b1);
    send(3'd4, -1048576,      32'h0000_00EF, 32'h8000_00EF, 1'b0, 1'b1);
    drain();

    send(3'd2, 3,             32'h0000_0063, 32'h0000_0063, 1'b1, 1'b1);
    send(3'd0, 2048,          32'h0000_0013, 32'h0000_0013, 1'b1, 1'b1);
    send(3'd5, 0,             32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b1, 1'b1);
    drain();
    chk("err_count_three", {30'b0, err_count}, 32'd3);
    send(3'd4, 1048576,       32'h0000_00EF, 32'h0000_00EF, 1'b1, 1'b1);
    send(3'd3, 32'h1234_5001, 32'h0000_0037, 32'h0000_0037, 1'b1, 1'b1);
    drain();
    chk("err_count_sat", {30'b0, err_count}, 32'd3);

    fork
      begin
        send(3'd0, 1,  32'h0000_0013, 32'h0010_0013, 1'b0, 1'b1);
        send(3'd0, 2,  32'h0000_0013, 32'h0020_0013, 1'b0, 1'b1);
        send(3'd0, 3,  32'h0000_0013, 32'h0030_0013, 1'b0, 1'b1);
        send(3'd0, -1, 32'h0000_0013, 32'hFFF0_0013, 1'b0, 1'b1);
      end
      begin
        repeat (2) @(posedge clk);
        #1 hold = 1'b1;
        repeat (3) @(posedge clk);
        #1 hold = 1'b0;
      end
    join
    drain();

    rnd_rdy = 1'b1;
    for (int n = 0; n < 500; n++) send_random();
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("midrst_in_ready", {31'b0, in_ready}, 32'd1);
    chk("midrst_instr", instr, 32'h0);
    chk("midrst_err_count", {30'b0, err_count}, 32'd0);
    sbq.delete();
    exp_cnt = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("post_rst_no_word", {31'b0, out_valid}, 32'd0);
    for (int n = 0; n < 500; n++) send_random();
    drain();
    rnd_rdy = 1'b0;
    chk("queue_empty", sbq.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
